// File: rtl/can_rx.sv
// CAN 2.0A receiver: bit destuffing, frame parsing, CRC-15 check, ACK drive.
module can_rx #(
  parameter int unsigned IDLE_BITS = 11,
  parameter logic [14:0] CRC_POLY  = 15'h4599
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_en,
  input  logic        rx,
  output logic [10:0] rx_id,
  output logic        rx_rtr,
  output logic [3:0]  rx_dlc,
  output logic [63:0] rx_data,
  output logic        rx_valid,
  output logic        ack_drive,
  output logic        crc_err,
  output logic        stuff_err,
  output logic        form_err,
  output logic        busy
);

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_BITS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC,
    S_CRC_DEL, S_ACK_SLOT, S_ACK_DEL, S_EOF, S_WAIT_IDLE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] data_last;
  logic [2:0]       stf_cnt;
  logic             stf_last;
  logic [14:0]      crc;
  logic [14:0]      crc_rx;
  logic [10:0]      id_sh;
  logic             rtr_r;
  logic [3:0]       dlc_sh;
  logic [63:0]      data_sh;

  logic        crc_nxt;
  logic [14:0] crc_upd;
  logic [3:0]  dlc_full;
  logic [3:0]  nbytes;
  logic        stuffed_field;
  logic        is_stuff;

  // CRC step, DLC decode and stuff-bit detection for the current sample
  assign crc_nxt  = rx ^ crc[14];
  assign crc_upd  = {crc[13:0], 1'b0} ^ (crc_nxt ? CRC_POLY : 15'd0);
  assign dlc_full = {dlc_sh[2:0], rx};
  assign nbytes   = rtr_r ? 4'd0 : ((dlc_full > 4'd8) ? 4'd8 : dlc_full);
  assign stuffed_field = (state inside {S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC});
  // a stuff bit may also follow the last CRC bit, landing in the CRC_DEL slot
  assign is_stuff = (stuffed_field || (state == S_CRC_DEL)) && (stf_cnt == 3'd5);
  assign busy     = (state != S_IDLE);

  // receive FSM, destuffer, field capture and registered strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      data_last <= '0;
      stf_cnt   <= '0;
      stf_last  <= 1'b0;
      crc       <= '0;
      crc_rx    <= '0;
      id_sh     <= '0;
      rtr_r     <= 1'b0;
      dlc_sh    <= '0;
      data_sh   <= '0;
      rx_id     <= '0;
      rx_rtr    <= 1'b0;
      rx_dlc    <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      ack_drive <= 1'b0;
      crc_err   <= 1'b0;
      stuff_err <= 1'b0;
      form_err  <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      crc_err   <= 1'b0;
      stuff_err <= 1'b0;
      form_err  <= 1'b0;
      if (sample_en) begin
        if (is_stuff) begin
          if (rx == stf_last) begin
            stuff_err <= 1'b1;
            state     <= S_WAIT_IDLE;
            cnt       <= '0;
          end else begin
            stf_last <= rx;
            stf_cnt  <= 3'd1;
          end
        end else begin
          if (stuffed_field) begin
            if (rx == stf_last) begin
              stf_cnt <= stf_cnt + 3'd1;
            end else begin
              stf_cnt  <= 3'd1;
              stf_last <= rx;
            end
          end
          case (state)
            S_IDLE: begin
              if (!rx) begin
                // SOF (dominant) shifted into a cleared register leaves it zero
                state    <= S_ID;
                crc      <= '0;
                crc_rx   <= '0;
                data_sh  <= '0;
                stf_cnt  <= 3'd1;
                stf_last <= 1'b0;
                cnt      <= '0;
              end
            end
            S_ID: begin
              id_sh <= {id_sh[9:0], rx};
              crc   <= crc_upd;
              if (cnt == CNT_W'(10)) begin
                state <= S_RTR;
                cnt   <= '0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            S_RTR: begin
              rtr_r <= rx;
              crc   <= crc_upd;
              state <= S_IDE;
            end
            S_IDE: begin
              crc <= crc_upd;
              if (rx) begin
                form_err <= 1'b1;
                state    <= S_WAIT_IDLE;
                cnt      <= '0;
              end else begin
                state <= S_R0;
              end
            end
            S_R0: begin
              crc   <= crc_upd;
              state <= S_DLC;
              cnt   <= '0;
            end
            S_DLC: begin
              dlc_sh <= dlc_full;
              crc    <= crc_upd;
              if (cnt == CNT_W'(3)) begin
                cnt       <= '0;
                data_last <= CNT_W'(7'({nbytes, 3'b000}) - 7'd1);
                state     <= (nbytes == 4'd0) ? S_CRC : S_DATA;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            S_DATA: begin
              data_sh[~cnt] <= rx;
              crc           <= crc_upd;
              if (cnt == data_last) begin
                state <= S_CRC;
                cnt   <= '0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            S_CRC: begin
              crc_rx <= {crc_rx[13:0], rx};
              if (cnt == CNT_W'(14)) begin
                state <= S_CRC_DEL;
                cnt   <= '0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            S_CRC_DEL: begin
              if (!rx) begin
                form_err <= 1'b1;
                state    <= S_WAIT_IDLE;
              end else if (crc_rx != crc) begin
                crc_err <= 1'b1;
                state   <= S_WAIT_IDLE;
              end else begin
                ack_drive <= 1'b1;
                state     <= S_ACK_SLOT;
              end
              cnt <= '0;
            end
            S_ACK_SLOT: begin
              ack_drive <= 1'b0;
              state     <= S_ACK_DEL;
            end
            S_ACK_DEL: begin
              cnt <= '0;
              if (!rx) begin
                form_err <= 1'b1;
                state    <= S_WAIT_IDLE;
              end else begin
                state <= S_EOF;
              end
            end
            S_EOF: begin
              if (!rx) begin
                form_err <= 1'b1;
                state    <= S_WAIT_IDLE;
                cnt      <= '0;
              end else if (cnt == CNT_W'(6)) begin
                rx_id    <= id_sh;
                rx_rtr   <= rtr_r;
                rx_dlc   <= dlc_sh;
                rx_data  <= data_sh;
                rx_valid <= 1'b1;
                state    <= S_IDLE;
                cnt      <= '0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            S_WAIT_IDLE: begin
              if (!rx) begin
                cnt <= '0;
              end else if (cnt == IDLE_LAST) begin
                state <= S_IDLE;
                cnt   <= '0;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
            default: begin
              state <= S_IDLE;
              cnt   <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_can_rx.sv
// Self-checking bench for can_rx: bench-built stuffed frames, event scoreboard.
module tb_can_rx;

  logic        clk;
  logic        rst;
  logic        sample_en;
  logic        rx;
  logic [10:0] rx_id;
  logic        rx_rtr;
  logic [3:0]  rx_dlc;
  logic [63:0] rx_data;
  logic        rx_valid;
  logic        ack_drive;
  logic        crc_err;
  logic        stuff_err;
  logic        form_err;
  logic        busy;

  can_rx dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .rx(rx),
    .rx_id(rx_id), .rx_rtr(rx_rtr), .rx_dlc(rx_dlc), .rx_data(rx_data),
    .rx_valid(rx_valid), .ack_drive(ack_drive), .crc_err(crc_err),
    .stuff_err(stuff_err), .form_err(form_err), .busy(busy)
  );

  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_CRC   = 2'd1;
  localparam logic [1:0] K_STUFF = 2'd2;
  localparam logic [1:0] K_FORM  = 2'd3;

  typedef struct packed {
    logic [1:0]  kind;
    logic [10:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } ev_t;

  ev_t  exp_q[$];
  ev_t  obs_q[$];
  logic stf[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_clks = 0;
  int   wide_strobes = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ev_t mk_ev(input logic [1:0] k, input logic [10:0] id,
                                input logic r, input logic [3:0] d, input logic [63:0] dat);
    ev_t e;
    e.kind = k; e.id = id; e.rtr = r; e.dlc = d; e.data = dat;
    return e;
  endfunction

  // records every strobe as an observed event, counts ACK clocks and long strobes
  initial begin
    logic prev_any;
    logic now_any;
    ev_t  m;
    prev_any = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (rx_valid) obs_q.push_back(mk_ev(K_VALID, rx_id, rx_rtr, rx_dlc, rx_data));
        if (crc_err)   obs_q.push_back(mk_ev(K_CRC, '0, 1'b0, '0, '0));
        if (stuff_err) obs_q.push_back(mk_ev(K_STUFF, '0, 1'b0, '0, '0));
        if (form_err)  obs_q.push_back(mk_ev(K_FORM, '0, 1'b0, '0, '0));
        if (ack_drive) ack_clks++;
        now_any = rx_valid | crc_err | stuff_err | form_err;
        if (now_any && prev_any) wide_strobes++;
        prev_any = now_any;
        m = '0;
      end else begin
        prev_any = 1'b0;
      end
    end
  end

  // one bit period = 4 clks, sample point on the 2nd clk edge
  task automatic bit_tx(input logic b);
    rx = b;
    @(posedge clk); #1;
    sample_en = 1'b1;
    @(posedge clk); #1;
    sample_en = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic ones(input int n);
    for (int i = 0; i < n; i++) bit_tx(1'b1);
  endtask

  // builds SOF..CRC with CRC-15 and bit stuffing into stf
  task automatic build(input logic [10:0] id, input logic rtr, input logic [3:0] dlc,
                       input logic [63:0] data, input logic flip_crc);
    logic        raw[$];
    logic [14:0] c;
    logic        nx;
    logic        prev;
    int          run;
    int          n;
    raw.delete();
    stf.delete();
    raw.push_back(1'b0);
    for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
    raw.push_back(rtr);
    raw.push_back(1'b0);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
    n = rtr ? 0 : ((dlc > 4'd8) ? 8 : int'(dlc));
    for (int i = 0; i < n * 8; i++) raw.push_back(data[63 - i]);
    c = '0;
    foreach (raw[i]) begin
      nx = raw[i] ^ c[14];
      c  = {c[13:0], 1'b0};
      if (nx) c = c ^ 15'h4599;
    end
    if (flip_crc) c[0] = ~c[0];
    for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
    run  = 0;
    prev = 1'b0;
    foreach (raw[i]) begin
      stf.push_back(raw[i]);
      if (run > 0 && raw[i] == prev) run++;
      else run = 1;
      prev = raw[i];
      if (run == 5) begin
        stf.push_back(~raw[i]);
        prev = ~raw[i];
        run  = 1;
      end
    end
  endtask

  task automatic send_stuffed(input int count);
    for (int i = 0; i < count && i < stf.size(); i++) bit_tx(stf[i]);
  endtask

  // CRC_DEL, bench ACK, ACK_DEL, EOF, short intermission
  task automatic send_tail();
    bit_tx(1'b1);
    bit_tx(1'b0);
    bit_tx(1'b1);
    ones(7);
    ones(3);
  endtask

  task automatic score(input string name);
    ev_t o;
    ev_t e;
    checks++;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: observed events %0d, expected events %0d", name, obs_q.size(), exp_q.size());
      obs_q.delete();
      exp_q.delete();
    end else begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      if (o !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h", name, o, e);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL %s_extra: %0d extra strobes, required 0", name, obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sample_en = 1'b0; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rx_id, rx_rtr, rx_dlc, rx_data, rx_valid, ack_drive, crc_err, stuff_err, form_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got id=%h dlc=%h data=%h busy=%b, required all 0", rx_id, rx_dlc, rx_data, busy);
    end
    rst = 1'b0;
    ones(3);
  endtask

  task automatic test_good_frame();
    ack_clks = 0;
    build(11'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, 1'b0);
    exp_q.push_back(mk_ev(K_VALID, 11'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000));
    send_stuffed(stf.size());
    send_tail();
    score("good_frame");
    checks++;
    if (ack_clks !== 4) begin
      errors++;
      $display("FAIL good_ack_width: got %0d clks, required 4", ack_clks);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL good_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_crc_error();
    ack_clks = 0;
    build(11'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, 1'b1);
    exp_q.push_back(mk_ev(K_CRC, '0, 1'b0, '0, '0));
    send_stuffed(stf.size());
    ones(11);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL crc_busy_wait: got %b required 1", busy);
    end
    bit_tx(1'b1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL crc_busy_idle: got %b required 0", busy);
    end
    score("crc_error");
    checks++;
    if (ack_clks !== 0) begin
      errors++;
      $display("FAIL crc_ack: got %0d clks, required 0", ack_clks);
    end
  endtask

  task automatic test_stuff_error();
    build(11'h000, 1'b0, 4'd0, 64'h0, 1'b0);
    stf[5] = 1'b0;
    exp_q.push_back(mk_ev(K_STUFF, '0, 1'b0, '0, '0));
    send_stuffed(6);
    ones(12);
    score("stuff_error");
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL stuff_busy: got %b required 0", busy);
    end
    build(11'h3A5, 1'b0, 4'd1, 64'h5A00_0000_0000_0000, 1'b0);
    exp_q.push_back(mk_ev(K_VALID, 11'h3A5, 1'b0, 4'd1, 64'h5A00_0000_0000_0000));
    send_stuffed(stf.size());
    send_tail();
    score("after_stuff_frame");
  endtask

  task automatic test_remote();
    build(11'h7F0, 1'b1, 4'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    exp_q.push_back(mk_ev(K_VALID, 11'h7F0, 1'b1, 4'd4, 64'h0));
    send_stuffed(stf.size());
    send_tail();
    score("remote_frame");
  endtask

  task automatic test_dlc15_form();
    build(11'h111, 1'b0, 4'd15, 64'h0102_0304_0506_0708, 1'b0);
    exp_q.push_back(mk_ev(K_VALID, 11'h111, 1'b0, 4'd15, 64'h0102_0304_0506_0708));
    send_stuffed(stf.size());
    send_tail();
    score("dlc15_frame");
    build(11'h222, 1'b0, 4'd15, 64'h1111_2222_3333_4444, 1'b0);
    exp_q.push_back(mk_ev(K_FORM, '0, 1'b0, '0, '0));
    send_stuffed(stf.size());
    bit_tx(1'b1);
    bit_tx(1'b0);
    bit_tx(1'b1);
    bit_tx(1'b1);
    bit_tx(1'b1);
    bit_tx(1'b0);
    ones(12);
    score("eof_form_error");
    checks++;
    if ({rx_id, rx_rtr, rx_dlc, rx_data} !== {11'h111, 1'b0, 4'd15, 64'h0102_0304_0506_0708}) begin
      errors++;
      $display("FAIL form_hold: got id=%h rtr=%b dlc=%h data=%h, required id=111 rtr=0 dlc=f data=0102030405060708",
               rx_id, rx_rtr, rx_dlc, rx_data);
    end
  endtask

  task automatic test_reset_midframe();
    build(11'h123, 1'b0, 4'd2, 64'hABCD_0000_0000_0000, 1'b0);
    send_stuffed(28);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({rx_id, rx_rtr, rx_dlc, rx_data, rx_valid, ack_drive, crc_err, stuff_err, form_err, busy} !== '0) begin
      errors++;
      $display("FAIL midframe_reset: got id=%h dlc=%h data=%h busy=%b, required all 0", rx_id, rx_dlc, rx_data, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rx  = 1'b1;
    ones(3);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL midframe_strobes: got %0d strobes, required 0", obs_q.size());
      obs_q.delete();
    end
    build(11'h555, 1'b0, 4'd1, 64'h3300_0000_0000_0000, 1'b0);
    exp_q.push_back(mk_ev(K_VALID, 11'h555, 1'b0, 4'd1, 64'h3300_0000_0000_0000));
    send_stuffed(stf.size());
    send_tail();
    score("post_reset_frame");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_error();
    test_stuff_error();
    test_remote();
    test_dlc15_form();
    test_reset_midframe();
    checks++;
    if (wide_strobes != 0) begin
      errors++;
      $display("FAIL strobe_width: got %0d multi-clk strobes, required 0", wide_strobes);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
